// File: rtl/mul_share_arb_pkg.sv
// Shared widths, stage-1 record and carry-save helper for the shared 8x8 multiplier block.
package mul_share_arb_pkg;
  localparam int MUL_NREQ = 4;
  localparam int MUL_W    = 8;
  localparam int MUL_IDW  = 2;
  localparam int MUL_PW   = 2 * MUL_W;

  typedef struct packed {
    logic [MUL_W-1:0]   a;
    logic [MUL_W-1:0]   b;
    logic [MUL_IDW-1:0] id;
    logic               valid;
  } s1_t;

  typedef struct packed {
    logic [MUL_PW:0] s;
    logic [MUL_PW:0] c;
  } csa_t;

  // 3:2 compressor over whole rows; the carry row is pre-shifted into place.
  function automatic csa_t csa(input logic [MUL_PW:0] x, input logic [MUL_PW:0] y,
                               input logic [MUL_PW:0] z);
    csa_t r;
    r.s = x ^ y ^ z;
    r.c = ((x & y) | (x & z) | (y & z)) << 1;
    return r;
  endfunction
endpackage

// File: rtl/mul_share_arb_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic            any
);
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int             idx;
      logic [IDW-1:0] idx_b;
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_b = IDW'(idx);
      if (!any && req[idx_b]) begin
        any          = 1'b1;
        grant[idx_b] = 1'b1;
        grant_id     = idx_b;
      end
    end
  end
endmodule

// File: rtl/wallace.sv
// Combinational unsigned 8x8 Wallace-tree multiplier: 8 partial products -> 2 rows -> one adder.
module wallace
  import mul_share_arb_pkg::*;
(
  input  logic [MUL_W-1:0] a,
  input  logic [MUL_W-1:0] b,
  output logic [MUL_PW:0]  p
);
  logic [MUL_PW:0] pp [MUL_W];
  csa_t l1_0, l1_1, l2_0, l2_1, l3_0, l4_0;

  always_comb begin
    for (int i = 0; i < MUL_W; i++) begin
      pp[i] = ({{(MUL_PW + 1 - MUL_W){1'b0}}, a} & {(MUL_PW + 1){b[i]}}) << i;
    end
  end

  // Reduction levels: 8 -> 6 -> 4 -> 3 -> 2 rows.
  assign l1_0 = csa(pp[0], pp[1], pp[2]);
  assign l1_1 = csa(pp[3], pp[4], pp[5]);
  assign l2_0 = csa(l1_0.s, l1_0.c, l1_1.s);
  assign l2_1 = csa(l1_1.c, pp[6], pp[7]);
  assign l3_0 = csa(l2_0.s, l2_0.c, l2_1.s);
  assign l4_0 = csa(l3_0.s, l3_0.c, l2_1.c);
  assign p    = l4_0.s + l4_0.c;
endmodule

// File: rtl/mul_share_arb.sv
// One shared 8x8 multiplier behind a round-robin arbiter with a 2-stage operand/result pipeline.
module mul_share_arb
  import mul_share_arb_pkg::*;
#(
  parameter int NREQ = MUL_NREQ,
  parameter int W    = MUL_W,
  parameter int IDW  = MUL_IDW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [IDW-1:0]    res_id,
  output logic [2*W-1:0]    res_p,
  output logic              busy
);
  s1_t             s1_q;
  logic            s2_valid;
  logic [2*W-1:0]  s2_p;
  logic [IDW-1:0]  s2_id;
  logic [IDW-1:0]  rr_ptr;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic            any;
  logic            s1_load, s2_load, accept;
  logic [W-1:0]    a_sel, b_sel;
  logic [2*W:0]    prod;
  logic            unused_prod_msb;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req      (req_valid),
    .ptr      (rr_ptr),
    .grant    (grant),
    .grant_id (grant_id),
    .any      (any)
  );

  assign s2_load = !s2_valid || res_ready;
  assign s1_load = !s1_q.valid || s2_load;
  // Gated by rst_n so nothing is offered as accepted while reset is held.
  assign accept    = rst_n && any && s1_load;
  assign req_ready = accept ? grant : '0;

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        a_sel = a_sel | req_a[i*W +: W];
        b_sel = b_sel | req_b[i*W +: W];
      end
    end
  end

  wallace u_mul (
    .a (s1_q.a),
    .b (s1_q.b),
    .p (prod)
  );
  assign unused_prod_msb = prod[2*W];

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      s1_q     <= '0;
      s2_valid <= 1'b0;
      s2_p     <= '0;
      s2_id    <= '0;
    end else begin
      if (accept) begin
        s1_q   <= '{a: a_sel, b: b_sel, id: grant_id, valid: 1'b1};
        rr_ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
      end else if (s2_load) begin
        s1_q.valid <= 1'b0;
      end
      if (s2_load) begin
        s2_p     <= prod[2*W-1:0];
        s2_id    <= s1_q.id;
        s2_valid <= s1_q.valid;
      end
    end
  end

  assign res_valid = s2_valid;
  assign res_p     = s2_p;
  assign res_id    = s2_id;
  assign busy      = s1_q.valid || s2_valid;
endmodule

// File: tb/tb_mul_share_arb.sv
// Self-checking bench for mul_share_arb: vector table, directed corner sequences, random scoreboard.
module tb_mul_share_arb;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a, req_b;
  logic              res_valid;
  logic              res_ready;
  logic [IDW-1:0]    res_id;
  logic [2*W-1:0]    res_p;
  logic              busy;

  int errors = 0;
  int checks = 0;

  mul_share_arb #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_p     (res_p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    res_ready = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    int          id;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;
  vec_t tbl [6];

  typedef struct {
    int id;
    int p;
  } exp_t;
  exp_t q [$];

  // Reference model state for the random phase.
  logic [NREQ-1:0] hold;
  logic [7:0]      ta [NREQ];
  logic [7:0]      tb [NREQ];
  int              mptr;
  int              waits [NREQ];
  bit              stall_prev;
  logic [15:0]     prev_p;
  logic [IDW-1:0]  prev_id;

  task automatic rand_cycle(input bit gen);
    logic [NREQ-1:0] exp_ready;
    int              acc;
    #1;
    res_ready = gen ? ($urandom_range(0, 3) != 0) : 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      if (!hold[i] && gen && $urandom_range(0, 1) == 1) begin
        hold[i] = 1'b1;
        ta[i]   = 8'($urandom);
        tb[i]   = 8'($urandom);
        set_ops(i, ta[i], tb[i]);
      end
    end
    req_valid = hold;
    #1;
    exp_ready = '0;
    if (q.size() < 2 || res_ready) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx = (mptr + k) % NREQ;
        if (exp_ready == '0 && hold[idx]) exp_ready[idx] = 1'b1;
      end
    end
    check("rand_ready", req_ready, exp_ready);
    check("rand_busy", busy, q.size() != 0);
    if (q.size() == 0) check("rand_idle_valid", res_valid, 1'b0);
    if (stall_prev) begin
      check("rand_stall_p", res_p, prev_p);
      check("rand_stall_id", res_id, prev_id);
    end
    if (res_valid && res_ready) begin
      if (q.size() == 0) begin
        check("rand_spurious", 1, 0);
      end else begin
        check("rand_id", res_id, q[0].id);
        check("rand_p", res_p, q[0].p);
        void'(q.pop_front());
      end
    end
    stall_prev = res_valid && !res_ready;
    prev_p     = res_p;
    prev_id    = res_id;
    acc = -1;
    for (int i = 0; i < NREQ; i++) if (req_ready[i] && req_valid[i]) acc = i;
    if (acc >= 0) begin
      q.push_back('{id: acc, p: int'(ta[acc]) * int'(tb[acc])});
      check("fairness", waits[acc] <= NREQ - 1, 1'b1);
      waits[acc] = 0;
      hold[acc]  = 1'b0;
      mptr       = (acc + 1) % NREQ;
      for (int j = 0; j < NREQ; j++) if (hold[j]) waits[j]++;
    end
    @(posedge clk);
  endtask

  initial begin
    tbl[0] = '{id: 0, a: 8'hFF, b: 8'hFF, p: 16'hFE01};
    tbl[1] = '{id: 1, a: 8'h00, b: 8'h5A, p: 16'h0000};
    tbl[2] = '{id: 2, a: 8'h80, b: 8'h02, p: 16'h0100};
    tbl[3] = '{id: 3, a: 8'h12, b: 8'h34, p: 16'h03A8};
    tbl[4] = '{id: 1, a: 8'h0F, b: 8'h0F, p: 16'h00E1};
    tbl[5] = '{id: 2, a: 8'hFF, b: 8'h01, p: 16'h00FF};

    // Reset state, with every requester asserting valid.
    rst_n = 1'b0; req_valid = '1; res_ready = 1'b1; req_a = '1; req_b = '1;
    #3;
    check("rst_ready", req_ready, 0);
    check("rst_valid", res_valid, 0);
    check("rst_p", res_p, 0);
    check("rst_id", res_id, 0);
    check("rst_busy", busy, 0);
    tick();
    rst_n = 1'b1; req_valid = '0;

    // Isolated single transactions with 2-stage latency.
    res_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      set_ops(tbl[t].id, tbl[t].a, tbl[t].b);
      req_valid = 4'(1 << tbl[t].id);
      #1;
      check("vec_ready", req_ready, 1 << tbl[t].id);
      tick();
      req_valid = '0;
      #1;
      check("vec_lat_valid", res_valid, 0);
      check("vec_lat_busy", busy, 1);
      tick();
      check("vec_valid", res_valid, 1);
      check("vec_p", res_p, tbl[t].p);
      check("vec_id", res_id, tbl[t].id);
      tick();
      check("vec_idle", busy, 0);
    end

    // All four requesting continuously: round robin at one result per cycle.
    do_reset();
    res_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_ops(i, 8'(i + 1), 8'h10);
    req_valid = '1;
    #1;
    for (int e = 0; e < 10; e++) begin
      check("rr_ready", req_ready, 1 << (e % 4));
      if (e >= 2) begin
        check("rr_valid", res_valid, 1);
        check("rr_id", res_id, (e - 2) % 4);
        check("rr_p", res_p, ((e - 2) % 4 + 1) * 16);
      end else begin
        check("rr_fill_valid", res_valid, 0);
      end
      tick();
    end

    // Backpressure: two deep, then stalled, then drained in order.
    do_reset();
    set_ops(1, 8'h11, 8'h03);
    set_ops(2, 8'h20, 8'h08);
    req_valid = 4'b0110;
    #1;
    check("bp_ready0", req_ready, 4'b0010);
    tick();
    req_valid = 4'b0100;
    #1;
    check("bp_ready1", req_ready, 4'b0100);
    check("bp_valid1", res_valid, 0);
    tick();
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("bp_stall_ready", req_ready, 0);
      check("bp_stall_valid", res_valid, 1);
      check("bp_stall_id", res_id, 1);
      check("bp_stall_p", res_p, 16'h0033);
      check("bp_stall_busy", busy, 1);
      tick();
    end
    req_valid = '0;
    res_ready = 1'b1;
    #1;
    check("bp_head_id", res_id, 1);
    tick();
    check("bp_drain_valid", res_valid, 1);
    check("bp_drain_id", res_id, 2);
    check("bp_drain_p", res_p, 16'h0100);
    tick();
    check("bp_empty_valid", res_valid, 0);
    check("bp_empty_busy", busy, 0);

    // Pointer wrap: after granting 3, requester 0 wins over 3.
    do_reset();
    res_ready = 1'b1;
    req_valid = 4'b1000;
    #1;
    check("wrap_ready3", req_ready, 4'b1000);
    tick();
    req_valid = 4'b1001;
    #1;
    check("wrap_ready0", req_ready, 4'b0001);
    tick();
    req_valid = 4'b1000;
    #1;
    check("wrap_ready3b", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    tick();
    tick();

    // Reset with both stages full: immediate clear, no stale result afterwards.
    do_reset();
    set_ops(0, 8'h07, 8'h09);
    set_ops(1, 8'h05, 8'h05);
    req_valid = 4'b0011;
    tick();
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    #1;
    check("mid_full_valid", res_valid, 1);
    check("mid_full_p", res_p, 16'h003F);
    req_valid = '1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", res_valid, 0);
    check("mid_rst_p", res_p, 0);
    check("mid_rst_id", res_id, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", req_ready, 0);
    tick();
    rst_n = 1'b1; req_valid = '0; res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("mid_after_valid", res_valid, 0);
      check("mid_after_busy", busy, 0);
    end

    // Random stress against the scoreboard model.
    do_reset();
    hold = '0; mptr = 0; stall_prev = 1'b0; prev_p = '0; prev_id = '0;
    for (int i = 0; i < NREQ; i++) waits[i] = 0;
    q.delete();
    for (int c = 0; c < 10000; c++) rand_cycle(1'b1);
    for (int c = 0; c < 40 && (q.size() != 0 || hold != '0); c++) rand_cycle(1'b0);
    check("drain_queue", q.size(), 0);
    check("drain_hold", hold, 0);
    #2;
    check("drain_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
